// File: rtl/dodge_pkg.sv
// Shared types and helpers for the LED-matrix dodge game engine.
package dodge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PLAY  = 3'd1,
    ST_PAUSE = 3'd2,
    ST_WIN   = 3'd3,
    ST_LOSE  = 3'd4
  } game_state_t;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Low bits of the LFSR select the spawn column; caller narrows to its column width.
  function automatic logic [15:0] spawn_col(input logic [15:0] lfsr, input int unsigned cols);
    return lfsr & 16'(cols - 1);
  endfunction

endpackage

// File: rtl/dodge_lfsr.sv
// 16-bit Galois LFSR (right shift) with seed and shift enable.
module dodge_lfsr
  import dodge_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [15:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= SEED;
    else if (en) q <= {1'b0, q[15:1]} ^ (q[0] ? LFSR_TAPS : '0);
  end

endmodule

// File: rtl/dodge_game_engine.sv
// Game-logic core: FSM, player, falling-object array, lives and timer for the dodge game.
module dodge_game_engine
  import dodge_pkg::*;
#(
  parameter int          COLS       = 8,
  parameter int          ROWS       = 8,
  parameter int          NUM_OBJ    = 3,
  parameter int          LIVES      = 3,
  parameter int          PLAYER_H   = 2,
  parameter int          TIME_LIMIT = 30,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                    CLK,
  input  logic                    clear_n,
  input  logic                    start,
  input  logic                    pause,
  input  logic                    mode,
  input  logic                    left,
  input  logic                    right,
  input  logic                    move_tick,
  input  logic                    sec_tick,
  input  logic [$clog2(COLS)-1:0] scan_col,
  output logic [ROWS-1:0]         obj_bits,
  output logic [ROWS-1:0]         player_bits,
  output logic [2:0]              state,
  output logic [2:0]              lives,
  output logic [7:0]              time_val,
  output logic                    hit,
  output logic                    game_over
);

  localparam int CW      = $clog2(COLS);
  localparam int RW      = $clog2(ROWS + 1);
  localparam int STAGGER = ROWS / NUM_OBJ;
  localparam int HIT_ROW = ROWS - PLAYER_H;
  localparam logic [ROWS-1:0] PLAYER_MASK = {ROWS{1'b1}} << HIT_ROW;

  game_state_t cur_state, next_state;
  logic [2:0]   lives_q, lives_n;
  logic [7:0]   time_q, time_n;
  logic         mode_q, mode_n;
  logic [CW-1:0] pcol_q, pcol_n;
  logic         hit_q, hit_n;

  logic [NUM_OBJ-1:0] act_q, act_n;
  logic [RW-1:0]      row_q [NUM_OBJ];
  logic [RW-1:0]      row_n [NUM_OBJ];
  logic [CW-1:0]      col_q [NUM_OBJ];
  logic [CW-1:0]      col_n [NUM_OBJ];
  logic [RW-1:0]      dly_q [NUM_OBJ];
  logic [RW-1:0]      dly_n [NUM_OBJ];

  logic [15:0]   lfsr_q;
  logic [CW-1:0] spawn_c;
  logic          collide, won;

  dodge_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk  (CLK),
    .rst_n(clear_n),
    .en   (1'b1),
    .q    (lfsr_q)
  );

  assign spawn_c = CW'(spawn_col(lfsr_q, COLS));

  always_ff @(posedge CLK or negedge clear_n) begin
    if (!clear_n) begin
      cur_state <= ST_IDLE;
      lives_q   <= 3'(LIVES);
      time_q    <= '0;
      mode_q    <= 1'b0;
      pcol_q    <= CW'(COLS / 2 - 1);
      hit_q     <= 1'b0;
      act_q     <= '0;
      for (int unsigned k = 0; k < NUM_OBJ; k++) begin
        row_q[k] <= '0;
        col_q[k] <= '0;
        dly_q[k] <= '0;
      end
    end else begin
      cur_state <= next_state;
      lives_q   <= lives_n;
      time_q    <= time_n;
      mode_q    <= mode_n;
      pcol_q    <= pcol_n;
      hit_q     <= hit_n;
      act_q     <= act_n;
      for (int unsigned k = 0; k < NUM_OBJ; k++) begin
        row_q[k] <= row_n[k];
        col_q[k] <= col_n[k];
        dly_q[k] <= dly_n[k];
      end
    end
  end

  always_comb begin
    next_state = cur_state;
    lives_n    = lives_q;
    time_n     = time_q;
    mode_n     = mode_q;
    pcol_n     = pcol_q;
    hit_n      = 1'b0;
    act_n      = act_q;
    collide    = 1'b0;
    won        = 1'b0;
    for (int unsigned k = 0; k < NUM_OBJ; k++) begin
      row_n[k] = row_q[k];
      col_n[k] = col_q[k];
      dly_n[k] = dly_q[k];
    end

    case (cur_state)
      ST_PLAY: begin
        if (pause) begin
          next_state = ST_PAUSE;
        end else begin
          if (move_tick) begin
            if (right && !left && pcol_q != CW'(COLS - 1)) pcol_n = pcol_q + 1'b1;
            else if (left && !right && pcol_q != '0)       pcol_n = pcol_q - 1'b1;

            // An object leaving the bottom row parks with delay 0 so it respawns on the next tick.
            for (int unsigned k = 0; k < NUM_OBJ; k++) begin
              if (act_q[k]) begin
                if (row_q[k] == RW'(ROWS - 1)) begin
                  act_n[k] = 1'b0;
                  dly_n[k] = '0;
                end else begin
                  row_n[k] = row_q[k] + 1'b1;
                end
              end else if (dly_q[k] > RW'(1)) begin
                dly_n[k] = dly_q[k] - 1'b1;
              end else begin
                dly_n[k] = '0;
                act_n[k] = 1'b1;
                row_n[k] = '0;
                col_n[k] = spawn_c;
              end
            end

            for (int unsigned k = 0; k < NUM_OBJ; k++)
              if (act_n[k] && col_n[k] == pcol_n && row_n[k] >= RW'(HIT_ROW)) collide = 1'b1;

            if (collide) begin
              hit_n = 1'b1;
              if (lives_q != '0) lives_n = lives_q - 1'b1;
              act_n = '0;
              for (int unsigned k = 0; k < NUM_OBJ; k++) dly_n[k] = RW'(k * STAGGER);
            end
          end

          if (sec_tick) begin
            if (mode_q) begin
              if (time_q != '0) time_n = time_q - 1'b1;
              if (time_q == 8'd1) won = 1'b1;
            end else if (time_q != 8'hFF) begin
              time_n = time_q + 1'b1;
            end
          end

          if (lives_n == '0) next_state = ST_LOSE;
          else if (won)      next_state = ST_WIN;
        end
      end

      ST_PAUSE: begin
        if (!pause) next_state = ST_PLAY;
      end

      default: begin
        if (start) begin
          next_state = ST_PLAY;
          lives_n    = 3'(LIVES);
          time_n     = mode ? 8'(TIME_LIMIT) : '0;
          mode_n     = mode;
          pcol_n     = CW'(COLS / 2 - 1);
          act_n      = '0;
          for (int unsigned k = 0; k < NUM_OBJ; k++) begin
            row_n[k] = '0;
            dly_n[k] = RW'(k * STAGGER);
          end
        end
      end
    endcase
  end

  always_comb begin
    obj_bits = '0;
    for (int unsigned k = 0; k < NUM_OBJ; k++)
      for (int unsigned r = 0; r < ROWS; r++)
        if (act_q[k] && col_q[k] == scan_col && row_q[k] == RW'(r)) obj_bits[r] = 1'b1;
  end

  assign player_bits = (pcol_q == scan_col) ? PLAYER_MASK : '0;
  assign state       = cur_state;
  assign lives       = lives_q;
  assign time_val    = time_q;
  assign hit         = hit_q;
  assign game_over   = (cur_state == ST_WIN) || (cur_state == ST_LOSE);

endmodule

// File: tb/tb_dodge_game_engine.sv
// Directed self-checking bench for dodge_game_engine (default 8x8 geometry, custom seed).
`timescale 1ns/1ps
module tb_dodge_game_engine;

  localparam logic [15:0] SEED = 16'h1D2B;

  logic       CLK = 1'b0;
  logic       clear_n = 1'b0;
  logic       start = 1'b0, pause = 1'b0, mode = 1'b0;
  logic       left = 1'b0, right = 1'b0, move_tick = 1'b0, sec_tick = 1'b0;
  logic [2:0] scan_col = '0;
  logic [7:0] obj_bits, player_bits;
  logic [2:0] state, lives;
  logic [7:0] time_val;
  logic       hit, game_over;

  int n_cmp = 0;
  int n_err = 0;
  int pc;
  logic [15:0] m_lfsr;

  typedef struct {
    logic l;
    logic r;
    int   exp_col;
  } mv_vec_t;
  mv_vec_t mv [19];

  dodge_game_engine #(.LFSR_SEED(SEED)) dut (
    .CLK(CLK), .clear_n(clear_n), .start(start), .pause(pause), .mode(mode),
    .left(left), .right(right), .move_tick(move_tick), .sec_tick(sec_tick),
    .scan_col(scan_col), .obj_bits(obj_bits), .player_bits(player_bits),
    .state(state), .lives(lives), .time_val(time_val), .hit(hit), .game_over(game_over)
  );

  always #10 CLK = ~CLK;

  // Reference LFSR predicts spawn columns
  always @(posedge CLK or negedge clear_n) begin
    if (!clear_n) m_lfsr <= SEED;
    else          m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input bit mt, input bit st, input bit l, input bit r);
    move_tick = mt; sec_tick = st; left = l; right = r;
    @(posedge CLK); #1;
    move_tick = 0; sec_tick = 0; left = 0; right = 0;
  endtask

  task automatic track_move(input bit l, input bit r);
    if (r && !l && pc < 7)      pc++;
    else if (l && !r && pc > 0) pc--;
  endtask

  task automatic get_map(output logic [63:0] m);
    m = '0;
    for (int c = 0; c < 8; c++) begin
      scan_col = 3'(c); #1;
      m[c*8 +: 8] = obj_bits;
    end
  endtask

  task automatic player_check(input string name);
    scan_col = 3'(pc); #1;
    check(name, player_bits, 8'hC0);
    scan_col = 3'(pc ^ 4); #1;
    check({name, "_other"}, player_bits, 8'h00);
  endtask

  task automatic fresh(input bit md);
    clear_n = 0;
    @(posedge CLK); #1;
    clear_n = 1; start = 1; mode = md;
    @(posedge CLK); #1;
    start = 0; pc = 3;
  endtask

  // Steer the player under object 0 so it hits on the 7th tick after objects were re-staggered.
  task automatic hunt(input bit sec_last, input bit chk_spawn);
    int c;
    logic [63:0] m;
    c = int'(m_lfsr[2:0]);
    for (int t = 1; t <= 7; t++) begin
      bit l, r;
      l = (pc > c);
      r = (pc < c);
      track_move(l, r);
      step(1, sec_last && (t == 7), l, r);
      check("hit_pulse", hit, 64'(t == 7));
      if (t == 1 && chk_spawn) begin
        get_map(m);
        check("spawn_map", m, 64'h1 << (c * 8));
      end
    end
    step(0, 0, 0, 0);
    check("hit_one_cycle", hit, 0);
  endtask

  initial begin
    logic [63:0] m, exp_map;
    int c0, c1;

    mv[0]  = '{0, 1, 4}; mv[1]  = '{0, 1, 5}; mv[2]  = '{0, 1, 6}; mv[3]  = '{0, 1, 7};
    mv[4]  = '{0, 1, 7}; mv[5]  = '{0, 1, 7}; mv[6]  = '{0, 1, 7};
    mv[7]  = '{1, 0, 6}; mv[8]  = '{1, 0, 5}; mv[9]  = '{1, 0, 4}; mv[10] = '{1, 0, 3};
    mv[11] = '{1, 0, 2}; mv[12] = '{1, 0, 1}; mv[13] = '{1, 0, 0}; mv[14] = '{1, 0, 0};
    mv[15] = '{1, 1, 0}; mv[16] = '{0, 1, 1}; mv[17] = '{1, 1, 1}; mv[18] = '{0, 0, 1};

    repeat (2) @(posedge CLK);
    #1;
    pc = 3;
    check("rst_state", state, 0);
    check("rst_lives", lives, 3);
    check("rst_time", time_val, 0);
    check("rst_hit", hit, 0);
    check("rst_game_over", game_over, 0);
    get_map(m);
    check("rst_objs", m, 0);
    player_check("rst_player");

    clear_n = 1; start = 1; mode = 1;
    @(posedge CLK); #1;
    start = 0;
    check("start_state", state, 1);
    check("start_lives", lives, 3);
    check("start_time", time_val, 30);
    player_check("start_player");

    for (int i = 0; i < 19; i++) begin
      step(1, 0, mv[i].l, mv[i].r);
      scan_col = 3'(mv[i].exp_col); #1;
      check($sformatf("move_col[%0d]", i), player_bits, 8'hC0);
    end
    check("move_state", state, 1);

    fresh(1);
    hunt(0, 1);
    check("hit_lives", lives, 2);
    get_map(m);
    check("hit_objs_cleared", m, 0);
    check("hit_state", state, 1);

    fresh(1);
    repeat (29) step(0, 1, 0, 0);
    check("lose_pre_time", time_val, 1);
    hunt(0, 0);
    check("lose_lives2", lives, 2);
    hunt(0, 0);
    check("lose_lives1", lives, 1);
    hunt(1, 0);
    check("lose_state", state, 4);
    check("lose_lives0", lives, 0);
    check("lose_time", time_val, 0);
    check("lose_game_over", game_over, 1);
    repeat (5) step(1, 1, 0, 1);
    check("lose_hold_state", state, 4);
    check("lose_hold_lives", lives, 0);
    check("lose_hold_time", time_val, 0);
    get_map(m);
    check("lose_hold_objs", m, 0);
    player_check("lose_hold_player");
    start = 1; mode = 1;
    @(posedge CLK); #1;
    start = 0;
    check("restart_state", state, 1);
    check("restart_lives", lives, 3);
    check("restart_time", time_val, 30);

    fresh(1);
    for (int i = 1; i <= 30; i++) begin
      step(0, 1, 0, 0);
      if (i == 1)  check("win_t1", time_val, 29);
      if (i == 29) begin
        check("win_t29", time_val, 1);
        check("win_t29_state", state, 1);
      end
    end
    check("win_state", state, 3);
    check("win_time", time_val, 0);
    check("win_game_over", game_over, 1);
    step(1, 1, 1, 0);
    check("win_hold_state", state, 3);
    check("win_hold_time", time_val, 0);
    start = 1; mode = 0;
    @(posedge CLK); #1;
    start = 0;
    check("endless_state", state, 1);
    check("endless_time0", time_val, 0);
    for (int i = 1; i <= 300; i++) begin
      step(0, 1, 0, 0);
      if (i == 254) check("endless_t254", time_val, 254);
    end
    check("endless_sat", time_val, 255);
    check("endless_state_end", state, 1);

    fresh(1);
    c0 = int'(m_lfsr[2:0]);
    step(1, 0, 0, 0);
    c1 = int'(m_lfsr[2:0]);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    exp_map = (64'h1 << (c0 * 8 + 2)) | (64'h1 << (c1 * 8 + 1));
    get_map(m);
    check("fall_map", m, exp_map);
    pause = 1;
    @(posedge CLK); #1;
    check("pause_state", state, 2);
    move_tick = 1; sec_tick = 1; left = 1;
    repeat (10) @(posedge CLK);
    #1;
    move_tick = 0; sec_tick = 0; left = 0;
    get_map(m);
    check("pause_map", m, exp_map);
    check("pause_time", time_val, 30);
    check("pause_hold_state", state, 2);
    player_check("pause_player");
    pause = 0;
    @(posedge CLK); #1;
    check("unpause_state", state, 1);
    get_map(m);
    check("unpause_map", m, exp_map);

    clear_n = 0; #1;
    check("clr_state", state, 0);
    check("clr_lives", lives, 3);
    check("clr_time", time_val, 0);
    check("clr_game_over", game_over, 0);
    get_map(m);
    check("clr_objs", m, 0);
    clear_n = 1;
    @(posedge CLK); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
